// File: rtl/gpr_wport_arbiter_if.sv
// GPR write-port sharing bus: three producer request channels plus the registered GPR write.
interface gpr_wport_arbiter_if;
  logic        p0_we;
  logic [4:0]  p0_a3;
  logic [31:0] p0_wd;
  logic        p0_stall;
  logic        p1_valid;
  logic [4:0]  p1_a3;
  logic [31:0] p1_wd;
  logic        p1_ready;
  logic        p2_valid;
  logic [4:0]  p2_a3;
  logic [31:0] p2_wd;
  logic        p2_ready;
  logic        gpr_we;
  logic [4:0]  gpr_a3;
  logic [31:0] gpr_wd;
  logic [1:0]  grant_id;

  modport master (
    output p0_we, p0_a3, p0_wd, p1_valid, p1_a3, p1_wd, p2_valid, p2_a3, p2_wd,
    input  p0_stall, p1_ready, p2_ready, gpr_we, gpr_a3, gpr_wd, grant_id
  );
  modport slave (
    input  p0_we, p0_a3, p0_wd, p1_valid, p1_a3, p1_wd, p2_valid, p2_a3, p2_wd,
    output p0_stall, p1_ready, p2_ready, gpr_we, gpr_a3, gpr_wd, grant_id
  );
endinterface

// File: rtl/gpr_wport_arbiter.sv
// Single GPR write port shared by pipeline (fixed priority) and two side producers
// (round-robin), with a starvation counter that forces side-producer service.
module gpr_wport_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic clr,
  gpr_wport_arbiter_if.slave bus
);
  localparam logic [1:0] G_P0 = 2'd0, G_P1 = 2'd1, G_P2 = 2'd2, G_NONE = 2'd3;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_q, starve_d;
  logic        rr_q, rr_d;          // 0: prefer p1, 1: prefer p2
  logic        gpr_we_q, gpr_we_d;
  logic [4:0]  gpr_a3_q, gpr_a3_d;
  logic [31:0] gpr_wd_q, gpr_wd_d;
  logic [1:0]  grant_q, grant_d;

  logic        r_side, forced;
  logic [1:0]  rr_pick, win;
  logic [4:0]  win_a3;
  logic [31:0] win_wd;

  always_comb begin
    r_side = bus.p1_valid | bus.p2_valid;
    if (bus.p1_valid && bus.p2_valid) rr_pick = rr_q ? G_P2 : G_P1;
    else if (bus.p1_valid)            rr_pick = G_P1;
    else if (bus.p2_valid)            rr_pick = G_P2;
    else                              rr_pick = G_NONE;
    forced = (starve_q == LIMIT) && r_side;

    if (clr)            win = G_NONE;
    else if (forced)    win = rr_pick;
    else if (bus.p0_we) win = G_P0;
    else                win = rr_pick;

    case (win)
      G_P0:    begin win_a3 = bus.p0_a3; win_wd = bus.p0_wd; end
      G_P1:    begin win_a3 = bus.p1_a3; win_wd = bus.p1_wd; end
      G_P2:    begin win_a3 = bus.p2_a3; win_wd = bus.p2_wd; end
      default: begin win_a3 = gpr_a3_q;  win_wd = gpr_wd_q;  end
    endcase

    // Counter only advances while a side producer is actually being denied by p0.
    starve_d = starve_q;
    if (!r_side || win == G_P1 || win == G_P2) starve_d = '0;
    else if (win == G_P0 && starve_q < LIMIT)  starve_d = starve_q + 4'd1;

    rr_d = rr_q;
    if (win == G_P1)      rr_d = 1'b1;
    else if (win == G_P2) rr_d = 1'b0;

    gpr_we_d = (win != G_NONE) && (win_a3 != 5'd0);
    gpr_a3_d = win_a3;
    gpr_wd_d = win_wd;
    grant_d  = win;
  end

  assign bus.p0_stall = bus.p0_we && (win != G_P0) && !clr;
  assign bus.p1_ready = (win == G_P1);
  assign bus.p2_ready = (win == G_P2);
  assign bus.gpr_we   = gpr_we_q;
  assign bus.gpr_a3   = gpr_a3_q;
  assign bus.gpr_wd   = gpr_wd_q;
  assign bus.grant_id = grant_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      starve_q <= '0;
      rr_q     <= 1'b0;
      gpr_we_q <= 1'b0;
      gpr_a3_q <= '0;
      gpr_wd_q <= '0;
      grant_q  <= G_NONE;
    end else begin
      starve_q <= starve_d;
      rr_q     <= rr_d;
      gpr_we_q <= gpr_we_d;
      gpr_a3_q <= gpr_a3_d;
      gpr_wd_q <= gpr_wd_d;
      grant_q  <= grant_d;
    end
  end
endmodule

// File: tb/tb_gpr_wport_arbiter.sv
// Directed bench for gpr_wport_arbiter: reset, priority, round-robin, starvation, $0, mid-run reset.
module tb_gpr_wport_arbiter;
  logic clk = 1'b0;
  logic clr;
  int   n_tests = 0;
  int   n_fail  = 0;

  gpr_wport_arbiter_if bus();
  gpr_wport_arbiter #(.STARVE_LIMIT(4)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after posedge; combinational outputs checked mid-cycle.
  task automatic mid();
    #4;
  endtask
  task automatic edge_();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.p0_we = 0; bus.p1_valid = 0; bus.p2_valid = 0;
  endtask

  task automatic clr_pulse();
    clr = 1; edge_(); clr = 0;
  endtask

  initial begin
    idle();
    bus.p0_a3 = 5'd1; bus.p0_wd = 32'hA0A0_0000;
    bus.p1_a3 = 5'd8; bus.p1_wd = 32'h1111_1111;
    bus.p2_a3 = 5'd9; bus.p2_wd = 32'h2222_2222;

    // 1. reset with all requesters active
    clr = 1; bus.p0_we = 1; bus.p1_valid = 1; bus.p2_valid = 1;
    #1;
    for (int c = 0; c < 2; c++) begin
      mid();
      chk("rst_p1_ready", 32'(bus.p1_ready), 0);
      chk("rst_p2_ready", 32'(bus.p2_ready), 0);
      chk("rst_p0_stall", 32'(bus.p0_stall), 0);
      edge_();
    end
    chk("rst_gpr_we", 32'(bus.gpr_we), 0);
    chk("rst_gpr_a3", 32'(bus.gpr_a3), 0);
    chk("rst_gpr_wd", bus.gpr_wd, 0);
    chk("rst_grant",  32'(bus.grant_id), 3);
    clr = 0; idle();

    // 2. pipeline only
    bus.p0_we = 1; bus.p0_a3 = 5'd5; bus.p0_wd = 32'h0000_1234;
    mid(); chk("p0_stall", 32'(bus.p0_stall), 0);
    edge_();
    chk("p0_gpr_we", 32'(bus.gpr_we), 1);
    chk("p0_gpr_a3", 32'(bus.gpr_a3), 5);
    chk("p0_gpr_wd", bus.gpr_wd, 32'h0000_1234);
    chk("p0_grant",  32'(bus.grant_id), 0);
    idle();
    edge_();
    chk("idle_gpr_we", 32'(bus.gpr_we), 0);
    chk("idle_grant",  32'(bus.grant_id), 3);
    chk("idle_hold_a3", 32'(bus.gpr_a3), 5);

    // 3. round-robin from reset
    clr_pulse();
    bus.p1_valid = 1; bus.p2_valid = 1;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk($sformatf("rr%0d_p1_ready", k), 32'(bus.p1_ready), (k % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_p2_ready", k), 32'(bus.p2_ready), (k % 2 == 0) ? 0 : 1);
      edge_();
      chk($sformatf("rr%0d_grant", k), 32'(bus.grant_id), (k % 2 == 0) ? 1 : 2);
      chk($sformatf("rr%0d_gpr_a3", k), 32'(bus.gpr_a3), (k % 2 == 0) ? 8 : 9);
    end
    idle();

    // 4. starvation, limit 4
    clr_pulse();
    bus.p0_we = 1; bus.p0_a3 = 5'd3; bus.p1_valid = 1;
    for (int k = 0; k < 6; k++) begin
      mid();
      chk($sformatf("st%0d_p1_ready", k), 32'(bus.p1_ready), (k == 4) ? 1 : 0);
      chk($sformatf("st%0d_p0_stall", k), 32'(bus.p0_stall), (k == 4) ? 1 : 0);
      edge_();
      chk($sformatf("st%0d_grant", k), 32'(bus.grant_id), (k == 4) ? 1 : 0);
    end
    chk("st_cnt_end", 32'(dut.starve_q), 1);
    idle();

    // 5. $0 write from p2
    edge_();
    bus.p2_valid = 1; bus.p2_a3 = 5'd0; bus.p2_wd = 32'hFFFF_FFFF;
    mid(); chk("z_p2_ready", 32'(bus.p2_ready), 1);
    edge_();
    chk("z_gpr_we", 32'(bus.gpr_we), 0);
    chk("z_grant",  32'(bus.grant_id), 2);
    chk("z_gpr_wd", bus.gpr_wd, 32'hFFFF_FFFF);
    idle(); bus.p2_a3 = 5'd9;

    // 6. reset mid-operation: build rr_ptr=2, starve_cnt=3
    clr_pulse();
    bus.p1_valid = 1; bus.p2_valid = 1;
    edge_();                                   // p1 wins, rr -> p2
    bus.p1_valid = 0; bus.p0_we = 1; bus.p0_a3 = 5'd4;
    for (int k = 0; k < 3; k++) edge_();       // p0 beats p2 three times
    chk("mr_cnt_pre", 32'(dut.starve_q), 3);
    chk("mr_rr_pre",  32'(dut.rr_q), 1);
    clr = 1;
    mid();
    chk("mr_clr_p2_ready", 32'(bus.p2_ready), 0);
    chk("mr_clr_p0_stall", 32'(bus.p0_stall), 0);
    edge_(); clr = 0;
    chk("mr_gpr_we", 32'(bus.gpr_we), 0);
    chk("mr_cnt",    32'(dut.starve_q), 0);
    chk("mr_rr",     32'(dut.rr_q), 0);
    bus.p0_we = 0; bus.p1_valid = 1; bus.p2_valid = 1;
    mid();
    chk("mr_p1_ready", 32'(bus.p1_ready), 1);
    chk("mr_p2_ready", 32'(bus.p2_ready), 0);
    edge_();
    chk("mr_grant", 32'(bus.grant_id), 1);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
